// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
// Shares one single-ported unified memory between the instruction-fetch (IF)
// port and the load/store (LS) port. One memory transaction is in flight at a
// time. LS normally wins contention, but a starvation counter forces an IF
// grant after STARVE_LIMIT consecutive LS grants made while IF was waiting.
//
// Handshake rules (all ports):
//   - A requester raises xReq and holds it, with its fields, until xAck. The
//     fields are captured only at grant. Later changes to Addr/WData do not
//     affect the transaction in flight.
//   - xAck is a registered one-cycle pulse. xRData is valid in that cycle and
//     then holds its value. Requests are not sampled during the Ack cycle, so
//     the requester can drop Req or raise it again without a double issue.
//   - MemReq is held, with MemWE/MemAddr/MemWData stable, until an edge that
//     samples MemReady=1. That edge completes the transaction. MemReady is
//     ignored whenever no transaction is outstanding.
//   - An asynchronous reset abandons any transaction in flight. MemReq drops at
//     once and no Ack is produced.
// dbg_state and dbg_starve_cnt expose the controller state for observation.

module imem_dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // instruction-fetch port
  input  logic          IFReq,
  input  logic [AW-1:0] IFAddr,
  output logic          IFAck,
  output logic [DW-1:0] IFRData,
  output logic          IFStall,
  // load/store port
  input  logic          LSReq,
  input  logic          LSWE,
  input  logic [AW-1:0] LSAddr,
  input  logic [DW-1:0] LSWData,
  output logic          LSAck,
  output logic [DW-1:0] LSRData,
  output logic          LSStall,
  // memory side
  output logic          MemReq,
  output logic          MemWE,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  input  logic [DW-1:0] MemRData,
  input  logic          MemReady,
  // observation
  output logic [1:0]    dbg_state,
  output logic [3:0]    dbg_starve_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t        state, state_nxt;
  logic [3:0]    starve_cnt, starve_cnt_nxt;
  logic          mem_req_nxt, mem_we_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic          if_ack_nxt, ls_ack_nxt;
  logic [DW-1:0] if_rdata_nxt, ls_rdata_nxt;

  // IF is forced ahead of LS only when both request and LS has used up its
  // run of consecutive grants.
  logic          if_forced;
  assign if_forced = IFReq && (starve_cnt == LIMIT);

  // Register the controller state and every registered output. Reset clears all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      MemReq     <= 1'b0;
      MemWE      <= 1'b0;
      MemAddr    <= '0;
      MemWData   <= '0;
      IFAck      <= 1'b0;
      LSAck      <= 1'b0;
      IFRData    <= '0;
      LSRData    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      MemReq     <= mem_req_nxt;
      MemWE      <= mem_we_nxt;
      MemAddr    <= mem_addr_nxt;
      MemWData   <= mem_wdata_nxt;
      IFAck      <= if_ack_nxt;
      LSAck      <= ls_ack_nxt;
      IFRData    <= if_rdata_nxt;
      LSRData    <= ls_rdata_nxt;
    end
  end

  // Next state, grant decision, memory-side capture and completion handling.
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    mem_req_nxt    = MemReq;
    mem_we_nxt     = MemWE;
    mem_addr_nxt   = MemAddr;
    mem_wdata_nxt  = MemWData;
    if_ack_nxt     = IFAck;
    ls_ack_nxt     = LSAck;
    if_rdata_nxt   = IFRData;
    ls_rdata_nxt   = LSRData;

    case (state)
      IDLE: begin
        if (LSReq && !if_forced) begin
          // LS grant. Count it against IF only when IF is actually waiting.
          state_nxt     = BUSY_LS;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = LSWE;
          mem_addr_nxt  = LSAddr;
          mem_wdata_nxt = LSWData;
          if (IFReq && (starve_cnt < LIMIT)) begin
            starve_cnt_nxt = starve_cnt + 4'd1;
          end
        end else if (IFReq) begin
          // IF grant. A fetch is always a read, and it resets the starvation run.
          state_nxt      = BUSY_IF;
          mem_req_nxt    = 1'b1;
          mem_we_nxt     = 1'b0;
          mem_addr_nxt   = IFAddr;
          mem_wdata_nxt  = '0;
          starve_cnt_nxt = 4'd0;
        end
      end

      BUSY_IF: begin
        if (MemReady) begin
          state_nxt    = DONE;
          mem_req_nxt  = 1'b0;
          mem_we_nxt   = 1'b0;
          if_ack_nxt   = 1'b1;
          if_rdata_nxt = MemRData;
        end
      end

      BUSY_LS: begin
        if (MemReady) begin
          state_nxt   = DONE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          ls_ack_nxt  = 1'b1;
          // A store returns no data, so LSRData keeps the last load result.
          if (!MemWE) begin
            ls_rdata_nxt = MemRData;
          end
        end
      end

      DONE: begin
        // This is the Ack cycle. Requests are deliberately not looked at here.
        state_nxt  = IDLE;
        if_ack_nxt = 1'b0;
        ls_ack_nxt = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stalls use the registered Ack, so the only combinational input path to them is Req.
  assign IFStall = IFReq & ~IFAck;
  assign LSStall = LSReq & ~LSAck;

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed testbench for imem_dmem_arbiter. Inputs are driven and outputs are
// sampled 1 ns after each rising edge. Every expected value is hand-derived.

module tb_imem_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          IFReq, LSReq, LSWE, MemReady;
  logic [AW-1:0] IFAddr, LSAddr;
  logic [DW-1:0] LSWData, MemRData;
  logic          IFAck, IFStall, LSAck, LSStall, MemReq, MemWE;
  logic [DW-1:0] IFRData, LSRData, MemWData;
  logic [AW-1:0] MemAddr;
  logic [1:0]    dbg_state;
  logic [3:0]    dbg_starve_cnt;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_if, exp_ls;

  imem_dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFReq(IFReq), .IFAddr(IFAddr), .IFAck(IFAck), .IFRData(IFRData), .IFStall(IFStall),
    .LSReq(LSReq), .LSWE(LSWE), .LSAddr(LSAddr), .LSWData(LSWData),
    .LSAck(LSAck), .LSRData(LSRData), .LSStall(LSStall),
    .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemReady(MemReady),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; IFReq = 1'b1; LSReq = 1'b1; LSWE = 1'b0;
    IFAddr = 32'h10; LSAddr = 32'h20; LSWData = 32'h0;
    MemReady = 1'b0; MemRData = 32'hA5A5_0001;
    repeat (3) tick();
    checks++;
    if ({MemReq, MemWE, IFAck, LSAck} !== 4'b0000)
      $display("FAIL reset_ctrl: got req/we/ifack/lsack=%b expected 0000", {MemReq, MemWE, IFAck, LSAck});
    checks++;
    if (MemAddr !== 32'h0 || MemWData !== 32'h0)
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0/0", MemAddr, MemWData);
    checks++;
    if (IFRData !== 32'h0 || LSRData !== 32'h0)
      $display("FAIL reset_rdata: got if=%h ls=%h expected 0/0", IFRData, LSRData);
    checks++;
    if (dbg_state !== 2'd0 || dbg_starve_cnt !== 4'd0)
      $display("FAIL reset_state: got state=%0d starve=%0d expected 0/0", dbg_state, dbg_starve_cnt);
    if ((IFAck | LSAck | MemReq | MemWE) !== 1'b0 || MemAddr !== 32'h0 || IFRData !== 32'h0) errors++;
    else if (MemWData !== 32'h0 || LSRData !== 32'h0 || dbg_state !== 2'd0 || dbg_starve_cnt !== 4'd0) errors++;
    // release: LS wins the tie and the pending IF is counted
    rst_n = 1'b1;
    tick();
    checks++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h20 || dbg_starve_cnt !== 4'd1) begin
      errors++;
      $display("FAIL reset_release_grant: got req=%b addr=%h starve=%0d expected 1/00000020/1", MemReq, MemAddr, dbg_starve_cnt);
    end
    MemReady = 1'b1;
    tick();
    checks++;
    if (LSAck !== 1'b1 || LSRData !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL reset_first_load: got ack=%b data=%h expected 1/a5a50001", LSAck, LSRData);
    end
    exp_ls = 32'hA5A5_0001;
    IFReq = 1'b0; LSReq = 1'b0;
    tick();
    tick();
    checks++;
    if (MemReq !== 1'b0 || LSAck !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: got req=%b ack=%b expected 0/0", MemReq, LSAck);
    end
  endtask

  task automatic test_single_fetch();
    int stall_n = 0, ack_n = 0, req_n = 0;
    IFAddr = 32'h100; MemRData = 32'h0050_0093; MemReady = 1'b1;
    IFReq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (IFStall) stall_n++;
      if (MemReq) begin
        req_n++;
        checks++;
        if (i != 1 || MemAddr !== 32'h100 || MemWE !== 1'b0) begin
          errors++;
          $display("FAIL fetch_memreq: got cycle=%0d addr=%h we=%b expected 1/00000100/0", i, MemAddr, MemWE);
        end
      end
      if (IFAck) begin
        ack_n++;
        checks++;
        if (i != 2 || IFRData !== 32'h0050_0093) begin
          errors++;
          $display("FAIL fetch_ack: got cycle=%0d data=%h expected 2/00500093", i, IFRData);
        end
        IFReq = 1'b0;
      end
      tick();
    end
    exp_if = 32'h0050_0093;
    checks++;
    if (stall_n != 2 || ack_n != 1 || req_n != 1) begin
      errors++;
      $display("FAIL fetch_counts: got stall=%0d ack=%0d req=%0d expected 2/1/1", stall_n, ack_n, req_n);
    end
    checks++;
    if (dbg_starve_cnt !== 4'd0) begin
      errors++;
      $display("FAIL fetch_starve_clear: got %0d expected 0", dbg_starve_cnt);
    end
  endtask

  task automatic test_load();
    LSWE = 1'b0; LSAddr = 32'h40; MemRData = 32'h1234_5678; MemReady = 1'b1;
    LSReq = 1'b1;
    tick();
    checks++;
    if (MemReq !== 1'b1 || MemWE !== 1'b0 || MemAddr !== 32'h40) begin
      errors++;
      $display("FAIL load_issue: got req=%b we=%b addr=%h expected 1/0/00000040", MemReq, MemWE, MemAddr);
    end
    tick();
    checks++;
    if (LSAck !== 1'b1 || LSRData !== 32'h1234_5678 || IFAck !== 1'b0 || IFRData !== exp_if) begin
      errors++;
      $display("FAIL load_ack: got ack=%b ls=%h ifack=%b if=%h expected 1/12345678/0/%h", LSAck, LSRData, IFAck, IFRData, exp_if);
    end
    exp_ls = 32'h1234_5678;
    LSReq = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_store_wait();
    MemReady = 1'b0; MemRData = 32'hFFFF_0000;
    LSWE = 1'b1; LSAddr = 32'h2000; LSWData = 32'hDEAD_BEEF;
    LSReq = 1'b1;
    tick();
    // fields change after grant and must not reach the memory
    LSAddr = 32'h3000; LSWData = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (MemReq !== 1'b1 || MemWE !== 1'b1 || MemAddr !== 32'h2000 || MemWData !== 32'hDEAD_BEEF || LSAck !== 1'b0) begin
        errors++;
        $display("FAIL store_hold_%0d: got req=%b we=%b addr=%h wdata=%h ack=%b expected 1/1/00002000/deadbeef/0",
                 k, MemReq, MemWE, MemAddr, MemWData, LSAck);
      end
      if (k == 4) MemReady = 1'b1;
      tick();
    end
    checks++;
    if (LSAck !== 1'b1 || LSRData !== exp_ls || MemReq !== 1'b0 || MemWE !== 1'b0) begin
      errors++;
      $display("FAIL store_ack: got ack=%b ls=%h req=%b we=%b expected 1/%h/0/0", LSAck, LSRData, MemReq, MemWE, exp_ls);
    end
    LSReq = 1'b0;
    tick();
    checks++;
    if (LSAck !== 1'b0) begin
      errors++;
      $display("FAIL store_ack_pulse: got ack=%b expected 0", LSAck);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [AW-1:0] exp_addr [7] = '{32'h400, 32'h400, 32'h400, 32'h400, 32'h300, 32'h400, 32'h400};
    int g = 0;
    logic prev = 1'b0;
    IFAddr = 32'h300; LSAddr = 32'h400; LSWE = 1'b0; MemRData = 32'h77; MemReady = 1'b1;
    IFReq = 1'b1; LSReq = 1'b1;
    for (int cyc = 0; cyc < 40 && g < 7; cyc++) begin
      if (MemReq && !prev) begin
        checks++;
        if (MemAddr !== exp_addr[g]) begin
          errors++;
          $display("FAIL grant_order_%0d: got addr=%h expected %h", g, MemAddr, exp_addr[g]);
        end
        if (g == 3) begin
          checks++;
          if (dbg_starve_cnt !== 4'd4) begin
            errors++;
            $display("FAIL starve_at_limit: got %0d expected 4", dbg_starve_cnt);
          end
        end
        if (g == 4) begin
          checks++;
          if (dbg_starve_cnt !== 4'd0 || MemWE !== 1'b0) begin
            errors++;
            $display("FAIL starve_cleared: got cnt=%0d we=%b expected 0/0", dbg_starve_cnt, MemWE);
          end
        end
        g++;
      end
      prev = MemReq;
      tick();
    end
    checks++;
    if (g != 7) begin
      errors++;
      $display("FAIL contention_timeout: got %0d grants expected 7", g);
    end
    IFReq = 1'b0; LSReq = 1'b0;
    repeat (3) tick();
    exp_if = 32'h77; exp_ls = 32'h77;
    checks++;
    if (IFRData !== exp_if || LSRData !== exp_ls || MemReq !== 1'b0) begin
      errors++;
      $display("FAIL contention_end: got if=%h ls=%h req=%b expected 77/77/0", IFRData, LSRData, MemReq);
    end
  endtask

  task automatic test_abort();
    logic ack_seen = 1'b0;
    logic done = 1'b0;
    LSWE = 1'b0; LSAddr = 32'h500; MemReady = 1'b0;
    LSReq = 1'b1;
    tick();
    checks++;
    if (MemReq !== 1'b1) begin
      errors++;
      $display("FAIL abort_issue: got req=%b expected 1", MemReq);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (MemReq !== 1'b0 || MemAddr !== 32'h0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL abort_async: got req=%b addr=%h state=%0d expected 0/0/0", MemReq, MemAddr, dbg_state);
    end
    LSReq = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_if = 32'h0; exp_ls = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (LSAck) ack_seen = 1'b1;
      tick();
    end
    checks++;
    if (ack_seen !== 1'b0 || LSRData !== exp_ls || IFRData !== exp_if) begin
      errors++;
      $display("FAIL abort_no_ack: got ack_seen=%b ls=%h if=%h expected 0/0/0", ack_seen, LSRData, IFRData);
    end
    MemRData = 32'hCAFE_0001; MemReady = 1'b1;
    LSReq = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (LSAck) done = 1'b1;
    end
    checks++;
    if (done !== 1'b1 || LSRData !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL abort_recover: got ack=%b data=%h expected 1/cafe0001", done, LSRData);
    end
    exp_ls = 32'hCAFE_0001;
    LSReq = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_withdraw();
    LSWE = 1'b0; LSAddr = 32'h600; MemRData = 32'h600D_600D; MemReady = 1'b0;
    LSReq = 1'b1;
    tick();
    LSReq = 1'b0;
    tick();
    checks++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h600) begin
      errors++;
      $display("FAIL withdraw_holds: got req=%b addr=%h expected 1/00000600", MemReq, MemAddr);
    end
    MemReady = 1'b1;
    tick();
    checks++;
    if (LSAck !== 1'b1 || LSRData !== 32'h600D_600D) begin
      errors++;
      $display("FAIL withdraw_ack: got ack=%b data=%h expected 1/600d600d", LSAck, LSRData);
    end
    // renew the request during the Ack cycle; nothing may issue until IDLE
    LSAddr = 32'h680; MemRData = 32'h0000_0680;
    LSReq = 1'b1;
    tick();
    checks++;
    if (MemReq !== 1'b0 || LSAck !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL done_no_issue: got req=%b ack=%b state=%0d expected 0/0/0", MemReq, LSAck, dbg_state);
    end
    tick();
    checks++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h680) begin
      errors++;
      $display("FAIL renew_issue: got req=%b addr=%h expected 1/00000680", MemReq, MemAddr);
    end
    tick();
    checks++;
    if (LSAck !== 1'b1 || LSRData !== 32'h0000_0680) begin
      errors++;
      $display("FAIL renew_ack: got ack=%b data=%h expected 1/00000680", LSAck, LSRData);
    end
    LSReq = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    exp_if = '0; exp_ls = '0;
    test_reset();
    test_single_fetch();
    test_load();
    test_store_wait();
    test_contention();
    test_abort();
    test_withdraw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // hard bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
